// File: rtl/top_level_pkg.sv
// Shared types for the relative-prime finder.
// Holds the word width, word type and FSM state encoding.
package top_level_pkg;

    localparam int WIDTH = 16;

    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        INIT,
        GCD,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/gcd_step.sv
// One combinational subtractive-Euclid step.
// Holds the pair once either side reaches zero; g is the resulting gcd.
module gcd_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic             zero_flag,
    output logic [WIDTH-1:0] g
);

    always_comb begin
        a_next    = a;
        b_next    = b;
        zero_flag = (a == '0) || (b == '0);
        g         = a + b;
        if (!zero_flag) begin
            if (a >= b) begin
                a_next = a - b;
            end else begin
                b_next = b - a;
            end
        end
    end

endmodule

// File: rtl/top_level.sv
// Relative-prime finder: smallest m >= decimal_two with gcd(n, m) == decimal_one.
// FSM walks candidates, running the subtractive GCD unit on each.
module top_level #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] register_value,
    input  logic [WIDTH-1:0] decimal_two,
    input  logic [WIDTH-1:0] decimal_one,
    input  logic             start,
    output logic [WIDTH-1:0] out
);

    import top_level_pkg::*;

    state_t state;

    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] one;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] res;

    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] g_sum;
    logic [WIDTH-1:0] m_inc;
    logic             zero_flag;

    assign m_inc = m + one;

    gcd_step #(
        .WIDTH(WIDTH)
    ) u_gcd_step (
        .a        (a),
        .b        (b),
        .a_next   (a_next),
        .b_next   (b_next),
        .zero_flag(zero_flag),
        .g        (g_sum)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            n     <= '0;
            one   <= '0;
            m     <= '0;
            a     <= '0;
            b     <= '0;
            g     <= '0;
            res   <= '0;
            out   <= '0;
        end else if (start && state != LOAD) begin
            // A new request aborts whatever is running; out is left alone.
            state <= LOAD;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= IDLE;
                end
                LOAD: begin
                    n   <= register_value;
                    m   <= decimal_two;
                    one <= decimal_one;
                    if (!start) begin
                        state <= INIT;
                    end
                end
                INIT: begin
                    if (n == '0) begin
                        res   <= '0;
                        state <= DONE;
                    end else begin
                        a     <= n;
                        b     <= m;
                        state <= GCD;
                    end
                end
                GCD: begin
                    if (zero_flag) begin
                        g     <= g_sum;
                        state <= CHECK;
                    end else begin
                        a <= a_next;
                        b <= b_next;
                    end
                end
                CHECK: begin
                    if (g == one) begin
                        res   <= m;
                        state <= DONE;
                    end else begin
                        m <= m_inc;
                        // Candidate space exhausted: report 0.
                        if (m_inc == '0) begin
                            res   <= '0;
                            state <= DONE;
                        end else begin
                            state <= INIT;
                        end
                    end
                end
                DONE: begin
                    out   <= res;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: scoreboard of expected results,
// with completion time taken from a cycle-count model of the algorithm.
module tb_top_level;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] register_value = '0;
    logic [15:0] decimal_two = 16'd2;
    logic [15:0] decimal_one = 16'd1;
    logic        start = 1'b0;
    logic [15:0] out;

    int errors = 0;
    int checks = 0;
    logic [15:0] prev = '0;
    logic [15:0] exp_q[$];

    top_level #(
        .WIDTH(16)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .register_value(register_value),
        .decimal_two   (decimal_two),
        .decimal_one   (decimal_one),
        .start         (start),
        .out           (out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, want);
        end
    endtask

    // Edges from the first LOAD cycle with start low until out updates.
    function automatic int latency(input int n, input int two, input int one);
        int lat;
        int m;
        int a;
        int b;
        int g;
        if (n == 0) return 2;
        lat = 0;
        m = two;
        forever begin
            lat += 1;
            a = n;
            b = m;
            lat += 1;
            while (a != 0 && b != 0) begin
                if (a >= b) a -= b;
                else b -= a;
                lat += 1;
            end
            lat += 1;
            g = (a + b) & 16'hffff;
            if (g == one) break;
            m = (m + one) & 16'hffff;
            if (m == 0) break;
        end
        return lat + 1;
    endfunction

    task automatic kick(input logic [15:0] n);
        @(posedge CLK);
        #1;
        register_value = n;
        start = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] n,
                       input logic [15:0] want);
        int lat;
        lat = latency(int'(n), 2, 1);
        exp_q.push_back(want);
        kick(n);
        @(posedge CLK);
        repeat (lat - 1) @(posedge CLK);
        #1;
        chk({tag, "_hold"}, out, prev);
        @(posedge CLK);
        #1;
        chk(tag, out, exp_q.pop_front());
        prev = out;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("reset_out", out, 16'd0);

        run("n5040", 16'd5040, 16'd11);
        run("n1", 16'd1, 16'd2);
        run("n9", 16'd9, 16'd2);
        run("n30", 16'd30, 16'd7);
        run("n6", 16'd6, 16'd5);
        run("n0", 16'd0, 16'd0);

        run("b2b_5040", 16'd5040, 16'd11);
        run("b2b_30", 16'd30, 16'd7);

        kick(16'd5040);
        repeat (300) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_mid", out, 16'd0);
        prev = 16'd0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (50) @(posedge CLK);
        #1;
        chk("rst_idle", out, 16'd0);
        run("post_rst_n9", 16'd9, 16'd2);

        kick(16'd5040);
        repeat (200) @(posedge CLK);
        #1;
        chk("abort_pre", out, prev);
        run("abort_n30", 16'd30, 16'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
